cgra_config_loader: RTL
=======================

CGRA_CONFIG_LOADER -- requirements
Module: cgra_config_loader

Interface
REQ-001 Parameter WORD_W, default 32, width of bitstream words accepted from the host.
REQ-002 Parameter CHAIN_LEN, default 1656, total config-chain length in bits (36 PEs x 46 bits).
REQ-003 Parameter CNT_W, default 11, bit-counter width, >= clog2(CHAIN_LEN+1).
REQ-004 Config_Clock  in  1  sole clock; all state changes on rising edge.
REQ-005 Config_Reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a chain load.
REQ-007 abort  in  1  one-cycle pulse that terminates a load in progress.
REQ-008 word_data  in  WORD_W  bitstream word, LSB shifted first.
REQ-009 word_valid  in  1  word_data valid.
REQ-010 word_ready  out  1  loader accepts word_data this cycle.
REQ-011 ConfigOut  out  1  serial bit driven to the chain head ConfigIn.
REQ-012 shift_en  out  1  chain advances one bit on this edge; chain holds when low.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  last load completed with all CHAIN_LEN bits.
REQ-015 bits_left  out  CNT_W  bits still to shift in the current load.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, SHIFT, DONE.
REQ-017 IDLE: start=1 -> FETCH; bits_left <= CHAIN_LEN; done <= 0.
REQ-018 FETCH: word_ready=1; on word_valid&word_ready, load the shift register with word_data, set the in-word counter to min(WORD_W, bits_left), and go to SHIFT.
REQ-019 FETCH with word_valid=0 SHALL stall indefinitely, with shift_en=0 and chain contents unchanged.
REQ-020 SHIFT: each cycle shift_en=1, ConfigOut=shreg[0], shreg >>= 1, bits_left and the in-word counter decrement by 1.
REQ-021 SHIFT -> FETCH when the in-word counter reaches 0 and bits_left > 0; SHIFT -> DONE when bits_left reaches 0.
REQ-022 Last word: only the bits_left remaining low-order bits are shifted; upper bits are discarded.
REQ-023 Throughput SHALL be WORD_W+1 cycles per full word (one FETCH cycle with valid high, then WORD_W shifts).
REQ-024 Total shift_en-high cycles per completed load SHALL equal CHAIN_LEN exactly.
REQ-025 DONE: done=1, busy=0 on the next cycle and held; start -> FETCH and clears done.
REQ-026 busy=1 in FETCH and SHIFT only; ConfigOut=0 whenever shift_en=0.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in FETCH or SHIFT -> IDLE next cycle: shift_en=0 that cycle, done=0, bits_left <= 0; the chain is left partially loaded. abort in IDLE or DONE has no effect.
REQ-029 start and abort in the same cycle: abort wins; start is ignored.
REQ-030 word_ready SHALL be 0 outside FETCH; word_data is never sampled outside FETCH.

Reset
REQ-031 Config_Reset low SHALL immediately force IDLE, word_ready=0, shift_en=0, ConfigOut=0, busy=0, done=0, bits_left=0, shreg=0.
REQ-032 Reset asserted mid-load SHALL discard the load; after release the block waits in IDLE for start.

Verification
REQ-033 CHAIN_LEN=46, start, words 0xA5A5A5A5 then 0x00003FFF, always valid -> 46 shift_en cycles; ConfigOut sequence is 1,0,1,0,0,1,0,1,... (32 bits), then fourteen 1s; done=1 at cycle 49 after start.
REQ-034 Same load with word_valid held low for 5 cycles before word1 -> shift_en=0 and ConfigOut=0 throughout the stall; bit sequence is unchanged; done is 5 cycles later.
REQ-035 abort on the 10th SHIFT cycle -> IDLE next cycle; busy=0, done=0, exactly 10 shift_en pulses total.
REQ-036 start pulsed during SHIFT, and start+abort in the same cycle -> no restart; abort takes effect; shift count is unaffected by the ignored start.
REQ-037 Config_Reset low during FETCH for one cycle -> all outputs 0 asynchronously; a subsequent start performs a full CHAIN_LEN load.
REQ-038 Back-to-back loads: start in DONE -> done drops the next cycle; second load yields a bit sequence identical to the first.

Source files
------------

// File: rtl/cgra_config_loader.sv
// ============================================================================
// Module      : cgra_config_loader
// Description : Streams host bitstream words LSB-first into the CGRA serial
//               configuration chain, one bit per shift_en cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cgra_config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1656,
    parameter int CNT_W     = 11
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ConfigOut,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_left
);

    localparam int c_WC_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WORD_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_bits_left;
    logic [c_WC_W-1:0]   r_word_cnt;

    logic w_start_go;
    logic w_abort_go;
    logic w_accept;
    logic w_shift;

    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // abort outranks every other request, including a same-cycle start
    always_comb begin
        w_state_next = r_state;
        w_start_go   = 1'b0;
        w_abort_go   = 1'b0;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    w_start_go   = 1'b1;
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    w_abort_go   = 1'b1;
                    w_state_next = IDLE;
                end else if (word_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (abort) begin
                    w_abort_go   = 1'b1;
                    w_state_next = IDLE;
                end else if (r_bits_left == CNT_W'(1)) begin
                    w_state_next = DONE;
                end else if (r_word_cnt == c_WC_W'(1)) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            r_shreg     <= '0;
            r_bits_left <= '0;
            r_word_cnt  <= '0;
        end else if (w_start_go) begin
            r_bits_left <= CNT_W'(CHAIN_LEN);
        end else if (w_abort_go) begin
            r_bits_left <= '0;
        end else if (w_accept) begin
            r_shreg <= word_data;
            // a short final word leaves its upper bits unshifted
            if (32'(r_bits_left) >= WORD_W) begin
                r_word_cnt <= c_WC_W'(WORD_W);
            end else begin
                r_word_cnt <= c_WC_W'(r_bits_left);
            end
        end else if (w_shift) begin
            r_shreg     <= r_shreg >> 1;
            r_bits_left <= r_bits_left - CNT_W'(1);
            r_word_cnt  <= r_word_cnt - c_WC_W'(1);
        end
    end

    assign word_ready = (r_state == FETCH);
    assign shift_en   = (r_state == SHIFT);
    assign ConfigOut  = (r_state == SHIFT) & r_shreg[0];
    assign busy       = (r_state == FETCH) || (r_state == SHIFT);
    assign done       = (r_state == DONE);
    assign bits_left  = r_bits_left;

endmodule

`default_nettype wire
